up_datapath_gen: RTL and testbench

- Parametrised successor to the 8-bit micro-processor datapath. It holds PC, SP, IR and a general register bank, and provides a combinational ALU and flags.
- It adds a sequential shift-add multiplier with busy/done handshake, registered Z/C/N flags, and sticky stack overflow/underflow detection.
- It sits between the control FSM (drives op/enables) and the memory bus (data_in/data_out).

---
 rtl/up_datapath_pkg.sv | 34 +++
 rtl/up_mul_seq.sv | 83 ++++++++
 rtl/up_datapath_gen.sv | 176 +++++++++++++++++
 tb/tb_up_datapath_gen.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_datapath_pkg.sv
// Shared encodings for the parametrised micro-processor datapath:
// ALU/op select codes, multiplier FSM states and an op classification helper.
package up_datapath_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_MUL    = 5'b00010;
    localparam logic [4:0] OP_NAND   = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_PASSA  = 5'b00101;
    localparam logic [4:0] OP_CONST0 = 5'b10000;
    localparam logic [4:0] OP_CONST1 = 5'b10001;
    localparam logic [4:0] OP_CONST2 = 5'b10010;
    localparam logic [4:0] OP_CONST3 = 5'b10011;
    localparam logic [4:0] OP_PCSHR  = 5'b10100;
    localparam logic [4:0] OP_PCINC  = 5'b10101;
    localparam logic [4:0] OP_SPINC  = 5'b10110;
    localparam logic [4:0] OP_SPDEC  = 5'b10111;
    localparam logic [4:0] OP_LOAD   = 5'b11000;
    localparam logic [4:0] OP_SP     = 5'b11001;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Ops whose result is allowed to update the Z/C/N flags.
    function automatic logic is_flag_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
               (op == OP_XOR) || (op == OP_PASSA);
    endfunction

endpackage

// File: rtl/up_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, DW cycles busy,
// followed by a single DONE cycle that presents the full 2*DW product.
module up_mul_seq
    import up_datapath_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic            start_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [2*DW-1:0] product_o
);

    localparam int CW = $clog2(DW + 1);

    mul_state_e      state_q;
    logic [2*DW-1:0] acc_q;
    logic [2*DW-1:0] mcand_q;
    logic [DW-1:0]   mplr_q;
    logic [CW-1:0]   count_q;
    logic            busy_q;
    logic            done_q;

    // Multiplier FSM with registered busy/done.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= MUL_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= MUL_RUN;
                        acc_q   <= '0;
                        mcand_q <= {{DW{1'b0}}, a_i};
                        mplr_q  <= b_i;
                        count_q <= CW'(DW);
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    if (mplr_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q <= {mcand_q[2*DW-2:0], 1'b0};
                    mplr_q  <= {1'b0, mplr_q[DW-1:1]};
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= MUL_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    state_q <= MUL_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= MUL_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/up_datapath_gen.sv
// Parametrised micro-processor datapath: PC/SP/IR, register bank, combinational
// ALU, registered flags, sticky stack bound errors and a sequential multiplier.
module up_datapath_gen
    import up_datapath_pkg::*;
#(
    parameter int            DW     = 8,
    parameter int            NREG   = 4,
    localparam int           RW     = $clog2(NREG),
    parameter int            PC_RST = 8,
    parameter logic [DW-1:0] SP_RST = '1
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic [DW-1:0] data_in,
    input  logic [4:0]    op,
    input  logic          op_valid,
    input  logic          ir_we,
    input  logic          pc_we,
    input  logic          sp_we,
    input  logic          rb_we,
    input  logic          rb_src,
    input  logic [RW-1:0] rb_dst,
    input  logic [RW-1:0] ra_sel,
    input  logic [RW-1:0] rb_sel,
    input  logic          flag_we,
    output logic [DW-1:0] data_out,
    output logic [3:0]    ir,
    output logic          busy,
    output logic          done,
    output logic          z,
    output logic          c,
    output logic          n,
    output logic          sp_ovf,
    output logic          sp_unf
);

    localparam logic [DW-1:0] PC_RST_V = DW'(PC_RST);
    localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ALL1     = '1;

    logic [DW-1:0]   pc_q, sp_q;
    logic [3:0]      ir_q;
    logic [DW-1:0]   regs_q [NREG];
    logic            z_q, c_q, n_q, ovf_q, unf_q;
    logic [RW-1:0]   mul_dst_q;
    logic            mul_we_q, mul_fwe_q;

    logic [DW-1:0]   a_s, b_s, alu_s;
    logic            alu_c_s, launch_s, mul_busy_s, mul_done_s;
    logic [2*DW-1:0] prod_s;
    logic [7:0]      ir_byte_s;

    assign a_s      = regs_q[ra_sel];
    assign b_s      = regs_q[rb_sel];
    assign launch_s = op_valid && (op == OP_MUL) && !mul_busy_s && !mul_done_s;

    // The IR nibbles always come from the most significant byte of the bus.
    if (DW >= 8) begin : g_ir_top
        assign ir_byte_s = data_in[DW-1 -: 8];
    end else begin : g_ir_narrow
        assign ir_byte_s = {{(8-DW){1'b0}}, data_in};
    end

    up_mul_seq #(.DW(DW)) u_mul (
        .clk       (clk),
        .nRst      (nRst),
        .start_i   (launch_s),
        .a_i       (a_s),
        .b_i       (b_s),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (prod_s)
    );

    // ALU result; the multiplier owns the bus during its DONE cycle.
    always_comb begin
        alu_s   = data_in;
        alu_c_s = 1'b0;
        if (mul_done_s) begin
            alu_s = prod_s[DW-1:0];
        end else begin
            case (op)
                OP_ADD:   {alu_c_s, alu_s} = {1'b0, a_s} + {1'b0, b_s};
                OP_SUB: begin
                    alu_s   = a_s - b_s;
                    alu_c_s = (a_s < b_s);
                end
                OP_MUL:   alu_s = '0;
                OP_NAND:  alu_s = ~(a_s & b_s);
                OP_XOR:   alu_s = a_s ^ b_s;
                OP_PASSA: alu_s = a_s;
                OP_CONST0, OP_CONST1, OP_CONST2, OP_CONST3:
                          alu_s = {{(DW-2){1'b0}}, op[1:0]};
                OP_PCSHR: alu_s = {1'b0, pc_q[DW-1:1]};
                OP_PCINC: alu_s = pc_q + ONE;
                OP_SPINC: alu_s = sp_q + ONE;
                OP_SPDEC: alu_s = sp_q - ONE;
                OP_SP:    alu_s = sp_q;
                default:  alu_s = data_in;
            endcase
        end
    end

    // PC, IR and SP; a push past the bottom or pop past the top holds SP.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pc_q  <= PC_RST_V;
            sp_q  <= SP_RST;
            ir_q  <= 4'h0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!mul_busy_s) begin
            if (pc_we) pc_q <= alu_s;
            if (ir_we) ir_q <= pc_q[0] ? ir_byte_s[3:0] : ir_byte_s[7:4];
            if (sp_we) begin
                if ((op == OP_SPDEC) && (sp_q == '0))       ovf_q <= 1'b1;
                else if ((op == OP_SPINC) && (sp_q == ALL1)) unf_q <= 1'b1;
                else                                          sp_q  <= alu_s;
            end
        end
    end

    // Destination and enables captured at MUL launch, consumed in DONE.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mul_dst_q <= '0;
            mul_we_q  <= 1'b0;
            mul_fwe_q <= 1'b0;
        end else if (launch_s) begin
            mul_dst_q <= rb_dst;
            mul_we_q  <= rb_we;
            mul_fwe_q <= flag_we;
        end
    end

    // Register bank; the launch-cycle write is deferred to the DONE write.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (mul_done_s && mul_we_q) begin
            regs_q[mul_dst_q] <= prod_s[DW-1:0];
        end else if (rb_we && !mul_busy_s && !launch_s) begin
            regs_q[rb_dst] <= rb_src ? alu_s : data_in;
        end
    end

    // Z/C/N flags; for MUL, C reports a non-zero upper product half.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
            n_q <= 1'b0;
        end else if (mul_done_s) begin
            if (mul_fwe_q) begin
                z_q <= (prod_s[DW-1:0] == '0);
                n_q <= prod_s[DW-1];
                c_q <= |prod_s[2*DW-1:DW];
            end
        end else if (flag_we && !mul_busy_s && is_flag_op(op)) begin
            z_q <= (alu_s == '0);
            n_q <= alu_s[DW-1];
            c_q <= alu_c_s;
        end
    end

    assign data_out = alu_s;
    assign ir       = ir_q;
    assign busy     = mul_busy_s;
    assign done     = mul_done_s;
    assign z        = z_q;
    assign c        = c_q;
    assign n        = n_q;
    assign sp_ovf   = ovf_q;
    assign sp_unf   = unf_q;

endmodule

// File: tb/tb_up_datapath_gen.sv
// Self-checking bench for up_datapath_gen: directed table, multiplier/stack/IR
// sequences, randomized run against an arithmetic model, and a DW=16 instance.
module tb_up_datapath_gen;
    import up_datapath_pkg::*;

    logic       clk, nRst;
    logic [7:0] data_in, data_out;
    logic [4:0] op;
    logic       op_valid, ir_we, pc_we, sp_we, rb_we, rb_src, flag_we;
    logic [1:0] rb_dst, ra_sel, rb_sel;
    logic [3:0] ir;
    logic       busy, done, z, c, n, sp_ovf, sp_unf;

    logic [15:0] d16_in, d16_out;
    logic [4:0]  d16_op;
    logic        d16_ov, d16_rb_we, d16_fwe;
    logic [2:0]  d16_dst, d16_ra, d16_rb;
    logic [3:0]  d16_ir;
    logic        d16_busy, d16_done, d16_z, d16_c, d16_n, d16_ovf, d16_unf;

    int checks = 0;
    int errors = 0;

    up_datapath_gen dut (
        .clk(clk), .nRst(nRst), .data_in(data_in), .op(op), .op_valid(op_valid),
        .ir_we(ir_we), .pc_we(pc_we), .sp_we(sp_we), .rb_we(rb_we), .rb_src(rb_src),
        .rb_dst(rb_dst), .ra_sel(ra_sel), .rb_sel(rb_sel), .flag_we(flag_we),
        .data_out(data_out), .ir(ir), .busy(busy), .done(done), .z(z), .c(c), .n(n),
        .sp_ovf(sp_ovf), .sp_unf(sp_unf)
    );

    up_datapath_gen #(.DW(16), .NREG(8)) dut16 (
        .clk(clk), .nRst(nRst), .data_in(d16_in), .op(d16_op), .op_valid(d16_ov),
        .ir_we(1'b0), .pc_we(1'b0), .sp_we(1'b0), .rb_we(d16_rb_we), .rb_src(1'b0),
        .rb_dst(d16_dst), .ra_sel(d16_ra), .rb_sel(d16_rb), .flag_we(d16_fwe),
        .data_out(d16_out), .ir(d16_ir), .busy(d16_busy), .done(d16_done),
        .z(d16_z), .c(d16_c), .n(d16_n), .sp_ovf(d16_ovf), .sp_unf(d16_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [4:0] op;
        logic [1:0] ra, rb, dst;
        logic       we, src, fwe;
        logic [7:0] din, exp_out;
        logic [2:0] exp_zcn;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [4:0] o, input logic [1:0] ra, rb, dst,
                                input logic we, src, fwe, input logic [7:0] din, eo,
                                input logic [2:0] zcn);
        vec_t v;
        v.op = o; v.ra = ra; v.rb = rb; v.dst = dst; v.we = we; v.src = src;
        v.fwe = fwe; v.din = din; v.exp_out = eo; v.exp_zcn = zcn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        op = OP_PASSA; op_valid = 1'b0; ir_we = 1'b0; pc_we = 1'b0; sp_we = 1'b0;
        rb_we = 1'b0; rb_src = 1'b0; rb_dst = 2'd0; ra_sel = 2'd0; rb_sel = 2'd0;
        flag_we = 1'b0; data_in = 8'h00;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [7:0] v);
        idle_in(); op = OP_LOAD; data_in = v; rb_we = 1'b1; rb_dst = r;
        tick();
        idle_in();
    endtask

    task automatic peek(input logic [4:0] o, input logic [1:0] r, output logic [7:0] v);
        idle_in(); op = o; ra_sel = r;
        #1;
        v = data_out;
    endtask

    // Launch r1*r2 into r0 with flags; optionally try a PC update while busy.
    task automatic do_mul(input logic [7:0] av, bv, input bit poke,
                          output int nbusy, output int done_at, output logic [7:0] dout);
        load_reg(2'd1, av);
        load_reg(2'd2, bv);
        op = OP_MUL; op_valid = 1'b1; ra_sel = 2'd1; rb_sel = 2'd2;
        rb_we = 1'b1; rb_dst = 2'd0; flag_we = 1'b1;
        tick();
        nbusy = 0; done_at = 0; dout = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            idle_in();
            if (poke && k == 3) begin op = OP_PCINC; pc_we = 1'b1; end
            #1;
            if (busy) nbusy++;
            if (done && done_at == 0) begin done_at = k; dout = data_out; end
            tick();
        end
        idle_in();
    endtask

    function automatic void model_alu(input logic [4:0] o, input int a, b, pcv, spv, din,
                                      output int res, output bit cy);
        cy = 1'b0;
        case (o)
            OP_ADD:   begin res = a + b; cy = (res > 255); end
            OP_SUB:   begin res = a - b; cy = (a < b); end
            OP_MUL:   res = 0;
            OP_NAND:  res = ~(a & b);
            OP_XOR:   res = a ^ b;
            OP_PASSA: res = a;
            OP_CONST0, OP_CONST1, OP_CONST2, OP_CONST3: res = int'(o) - 16;
            OP_PCSHR: res = pcv / 2;
            OP_PCINC: res = pcv + 1;
            OP_SPINC: res = spv + 1;
            OP_SPDEC: res = spv - 1;
            OP_SP:    res = spv;
            default:  res = din;
        endcase
        res = res & 255;
    endfunction

    logic [4:0] ops [16];
    int   m_pc, m_sp, m_ir, m_z, m_c, m_n, m_ovf, m_unf;
    int   m_regs [4];

    initial begin
        logic [7:0] v;
        int nb, da, res, din, ma, mb, mdst, mwe, mfwe, prod;
        bit cy, launch;
        logic [4:0] o;

        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_NAND, OP_XOR, OP_PASSA, OP_CONST0, OP_CONST1,
                OP_CONST2, OP_CONST3, OP_PCSHR, OP_PCINC, OP_SPINC, OP_SPDEC, OP_LOAD, OP_SP};
        tbl[0]  = mk(OP_LOAD,  2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'hF0, 3'b000);
        tbl[1]  = mk(OP_LOAD,  2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 3'b000);
        tbl[2]  = mk(OP_ADD,   2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b1, 8'h00, 8'h10, 3'b010);
        tbl[3]  = mk(OP_SUB,   2'd2, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h30, 3'b010);
        tbl[4]  = mk(OP_PASSA, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 3'b000);
        tbl[5]  = mk(OP_NAND,  2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hDF, 3'b001);
        tbl[6]  = mk(OP_XOR,   2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'b100);
        tbl[7]  = mk(OP_CONST3,2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 3'b100);
        tbl[8]  = mk(OP_CONST2,2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 3'b100);
        tbl[9]  = mk(OP_PCSHR, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 3'b100);
        tbl[10] = mk(OP_SPDEC, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 3'b100);
        tbl[11] = mk(5'b01111, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 3'b100);
        tbl[12] = mk(OP_MUL,   2'd1, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 3'b100);
        tbl[13] = mk(OP_ADD,   2'd3, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h20, 3'b000);
        tbl[14] = mk(OP_SUB,   2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'b100);

        idle_in();
        d16_in = 16'h0000; d16_op = OP_PASSA; d16_ov = 1'b0; d16_rb_we = 1'b0;
        d16_fwe = 1'b0; d16_dst = 3'd0; d16_ra = 3'd0; d16_rb = 3'd0;
        nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;

        // Reset state
        #1;
        chk("rst_busy", busy, 1'b0); chk("rst_done", done, 1'b0);
        chk("rst_zcn", {z, c, n}, 3'b000); chk("rst_ir", ir, 4'h0);
        chk("rst_sp_err", {sp_ovf, sp_unf}, 2'b00);
        peek(OP_PCINC, 2'd0, v); chk("rst_pc_plus1", v, 8'h09);
        peek(OP_SP, 2'd0, v);    chk("rst_sp", v, 8'hFF);
        for (int r = 0; r < 4; r++) begin
            peek(OP_PASSA, 2'(r), v); chk("rst_reg", v, 8'h00);
        end

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            idle_in();
            op = tbl[i].op; ra_sel = tbl[i].ra; rb_sel = tbl[i].rb; rb_dst = tbl[i].dst;
            rb_we = tbl[i].we; rb_src = tbl[i].src; flag_we = tbl[i].fwe; data_in = tbl[i].din;
            #1;
            chk($sformatf("tbl%0d_out", i), data_out, tbl[i].exp_out);
            tick();
            chk($sformatf("tbl%0d_zcn", i), {z, c, n}, tbl[i].exp_zcn);
            chk($sformatf("tbl%0d_busy", i), busy, 1'b0);
        end
        peek(OP_PASSA, 2'd0, v); chk("tbl_r0", v, 8'h20);

        // Multiplier with a PC write attempted while busy
        do_mul(8'h0D, 8'h0B, 1'b1, nb, da, v);
        chk("mul1_busy_cycles", nb, 8); chk("mul1_done_cycle", da, 9);
        chk("mul1_done_out", v, 8'h8F);
        chk("mul1_zcn", {z, c, n}, 3'b001);
        peek(OP_PASSA, 2'd0, v); chk("mul1_r0", v, 8'h8F);
        peek(OP_PCINC, 2'd0, v); chk("mul1_pc_held", v, 8'h09);

        do_mul(8'h20, 8'h10, 1'b0, nb, da, v);
        chk("mul2_done_out", v, 8'h00); chk("mul2_zcn", {z, c, n}, 3'b110);
        peek(OP_PASSA, 2'd0, v); chk("mul2_r0", v, 8'h00);

        // Async reset in the middle of RUN
        load_reg(2'd1, 8'h03); load_reg(2'd2, 8'h05);
        op = OP_MUL; op_valid = 1'b1; ra_sel = 2'd1; rb_sel = 2'd2;
        rb_we = 1'b1; rb_dst = 2'd3; flag_we = 1'b1;
        tick(); idle_in(); tick(); tick();
        chk("abort_busy_before", busy, 1'b1);
        nRst = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0); chk("abort_done", done, 1'b0);
        #1 nRst = 1'b1;
        da = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (done) da = 1;
            tick();
        end
        chk("abort_no_done", da, 0);
        peek(OP_PASSA, 2'd3, v); chk("abort_r3", v, 8'h00);
        chk("abort_zcn", {z, c, n}, 3'b000);
        do_mul(8'h07, 8'h09, 1'b0, nb, da, v);
        chk("mul3_done_out", v, 8'h3F); chk("mul3_done_cycle", da, 9);

        // Stack bounds
        idle_in(); op = OP_SPINC; sp_we = 1'b1; tick();
        chk("unf_set", sp_unf, 1'b1); chk("unf_ovf_clear", sp_ovf, 1'b0);
        peek(OP_SP, 2'd0, v); chk("unf_sp_held", v, 8'hFF);
        op = OP_CONST0; sp_we = 1'b1; tick();
        op = OP_SPDEC; sp_we = 1'b1; tick();
        chk("ovf_set", sp_ovf, 1'b1);
        peek(OP_SP, 2'd0, v); chk("ovf_sp_held", v, 8'h00);
        op = OP_SPINC; sp_we = 1'b1; tick();
        peek(OP_SP, 2'd0, v); chk("sp_inc", v, 8'h01);
        chk("sticky", {sp_ovf, sp_unf}, 2'b11);

        // IR nibble selection by PC parity
        idle_in(); data_in = 8'hA5; ir_we = 1'b1; tick();
        chk("ir_hi", ir, 4'hA);
        idle_in(); op = OP_PCINC; pc_we = 1'b1; tick();
        idle_in(); data_in = 8'hA5; ir_we = 1'b1; tick();
        chk("ir_lo", ir, 4'h5);

        // Randomized run against the model
        idle_in();
        nRst = 1'b0; #2 nRst = 1'b1;
        tick();
        m_pc = 8; m_sp = 255; m_ir = 0; m_z = 0; m_c = 0; m_n = 0; m_ovf = 0; m_unf = 0;
        for (int r = 0; r < 4; r++) m_regs[r] = 0;
        for (int it = 0; it < 400; it++) begin
            o = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 15)];
            op = o; op_valid = 1'($urandom); ir_we = 1'($urandom); pc_we = ($urandom_range(0, 3) == 0);
            sp_we = ($urandom_range(0, 3) == 0); rb_we = 1'($urandom); rb_src = 1'($urandom);
            rb_dst = 2'($urandom); ra_sel = 2'($urandom); rb_sel = 2'($urandom);
            flag_we = 1'($urandom); data_in = 8'($urandom);
            din = int'(data_in);
            #1;
            model_alu(o, m_regs[ra_sel], m_regs[rb_sel], m_pc, m_sp, din, res, cy);
            chk("rnd_out", data_out, res);
            launch = (o == OP_MUL) && op_valid;
            ma = m_regs[ra_sel]; mb = m_regs[rb_sel];
            mdst = int'(rb_dst); mwe = int'(rb_we); mfwe = int'(flag_we);
            if (ir_we) m_ir = (m_pc % 2 == 1) ? (din % 16) : (din / 16);
            if (pc_we) m_pc = res;
            if (sp_we) begin
                if (o == OP_SPDEC && m_sp == 0) m_ovf = 1;
                else if (o == OP_SPINC && m_sp == 255) m_unf = 1;
                else m_sp = res;
            end
            if (rb_we && !launch) m_regs[rb_dst] = rb_src ? res : din;
            if (flag_we && (o == OP_ADD || o == OP_SUB || o == OP_NAND || o == OP_XOR || o == OP_PASSA)) begin
                m_z = (res == 0); m_c = cy; m_n = (res >= 128);
            end
            tick();
            if (launch) begin
                for (int k = 0; k < 8; k++) begin
                    o = ops[$urandom_range(0, 15)];
                    op = o; op_valid = 1'($urandom); ir_we = 1'($urandom); pc_we = 1'($urandom);
                    sp_we = 1'($urandom); rb_we = 1'($urandom); rb_dst = 2'($urandom);
                    ra_sel = 2'($urandom); rb_sel = 2'($urandom); flag_we = 1'($urandom);
                    data_in = 8'($urandom);
                    #1;
                    model_alu(o, m_regs[ra_sel], m_regs[rb_sel], m_pc, m_sp, int'(data_in), res, cy);
                    chk("rnd_busy_out", data_out, res);
                    chk("rnd_busy", busy, 1'b1);
                    tick();
                end
                idle_in();
                #1;
                prod = ma * mb;
                chk("rnd_done", {busy, done}, 2'b01);
                chk("rnd_mul_out", data_out, prod & 255);
                tick();
                if (mwe) m_regs[mdst] = prod & 255;
                if (mfwe) begin m_z = ((prod & 255) == 0); m_c = (prod > 255); m_n = ((prod & 128) != 0); end
                chk("rnd_done_end", done, 1'b0);
            end
            chk("rnd_zcn", {z, c, n}, {1'(m_z), 1'(m_c), 1'(m_n)});
            chk("rnd_ir", ir, m_ir);
            chk("rnd_sp_err", {sp_ovf, sp_unf}, {1'(m_ovf), 1'(m_unf)});
        end
        for (int r = 0; r < 4; r++) begin
            peek(OP_PASSA, 2'(r), v); chk("rnd_reg", v, m_regs[r]);
        end

        // DW=16, NREG=8 instance
        d16_op = OP_LOAD; d16_in = 16'hFFFF; d16_rb_we = 1'b1; d16_dst = 3'd1; tick();
        d16_in = 16'h0001; d16_dst = 3'd2; tick();
        d16_in = 16'h1234; d16_dst = 3'd6; tick();
        d16_in = 16'h0100; d16_dst = 3'd7; tick();
        d16_op = OP_ADD; d16_ra = 3'd1; d16_rb = 3'd2; d16_rb_we = 1'b0; d16_fwe = 1'b1;
        #1; chk("w16_add_out", d16_out, 16'h0000);
        tick(); chk("w16_add_zcn", {d16_z, d16_c, d16_n}, 3'b110);
        d16_op = OP_MUL; d16_ov = 1'b1; d16_ra = 3'd6; d16_rb = 3'd7; d16_rb_we = 1'b1;
        d16_dst = 3'd5; tick();
        d16_op = OP_PASSA; d16_ov = 1'b0; d16_rb_we = 1'b0; d16_fwe = 1'b0; d16_ra = 3'd5;
        da = 0; res = 0;
        for (int k = 1; k <= 24; k++) begin
            #1;
            if (d16_done && da == 0) begin da = k; res = int'(d16_out); end
            tick();
        end
        chk("w16_mul_cycle", da, 17); chk("w16_mul_out", res, 16'h3400);
        chk("w16_mul_zcn", {d16_z, d16_c, d16_n}, 3'b010);
        #1; chk("w16_r5", d16_out, 16'h3400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
